// File: rtl/mem_resp.sv
// Queued line-read / word-write memory responder with fixed service latency.
// Optional MEM_RESP_STATS_EN adds saturating completion counters.
module mem_resp #(
  parameter int unsigned REG_WIDTH   = 32,
  parameter int unsigned PA_WIDTH    = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned LINE_BYTES  = 16,
  parameter int unsigned MEM_LINES   = 256,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic [PA_WIDTH-1:0]         i_addr,
  input  logic [REG_WIDTH-1:0]        i_data,
  input  logic                        i_write,
  input  logic                        i_ack,
  output logic                        o_full,
  output logic                        o_enable,
  output logic [LINE_BYTES*8-1:0]     o_data,
  output logic [ID_WIDTH-1:0]         o_id_request,
  output logic [ID_WIDTH-1:0]         o_id_response
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]                 o_read_count,
  output logic [15:0]                 o_write_count
`endif
);

  localparam int unsigned LINE_WIDTH = LINE_BYTES * 8;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W      = $clog2(MEM_LINES);
  localparam int unsigned WORD_BYTES = REG_WIDTH / 8;
  localparam int unsigned WB_W       = $clog2(WORD_BYTES);
  localparam int unsigned WORDS      = LINE_BYTES / WORD_BYTES;
  localparam int unsigned SLOT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W      = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count, count_d;
  logic                  push_c, pop_c, mem_we_c, resp_load_c;

  logic                  q_write [QUEUE_DEPTH];
  logic [IDX_W-1:0]      q_idx   [QUEUE_DEPTH];
  logic [SLOT_W-1:0]     q_slot  [QUEUE_DEPTH];
  logic [REG_WIDTH-1:0]  q_data  [QUEUE_DEPTH];
  logic [ID_WIDTH-1:0]   q_id    [QUEUE_DEPTH];
  logic [LINE_WIDTH-1:0] mem     [MEM_LINES];

  logic [OFF_W-1:0]      req_off_c;
  logic [IDX_W-1:0]      req_idx_c;
  logic [SLOT_W-1:0]     req_slot_c;
  logic                  unused_addr;

  // Address decode: bits above the line index are ignored.
  assign req_off_c   = i_addr[OFF_W-1:0];
  assign req_idx_c   = i_addr[OFF_W +: IDX_W];
  assign req_slot_c  = SLOT_W'(req_off_c >> WB_W);
  assign unused_addr = ^(i_addr >> (OFF_W + IDX_W));

  // A full queue drops the request even if the head pops on the same edge.
  assign push_c  = i_enable & ~o_full;
  assign count_d = count + (PTR_W+1)'(push_c) - (PTR_W+1)'(pop_c);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop_c       = 1'b0;
    mem_we_c    = 1'b0;
    resp_load_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (q_write[rd_ptr]) begin
            mem_we_c = 1'b1;
            pop_c    = 1'b1;
            state_d  = IDLE;
          end else begin
            resp_load_c = 1'b1;
            state_d     = RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (i_ack) begin
          pop_c   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_full        <= 1'b0;
      o_enable      <= 1'b0;
      o_data        <= '0;
      o_id_request  <= '0;
      o_id_response <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count    <= count_d;
      o_full   <= (count_d == (PTR_W+1)'(QUEUE_DEPTH));
      o_enable <= (state_d == RESP);
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!i_write) o_id_request <= o_id_request + ID_WIDTH'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      if (resp_load_c) begin
        o_data        <= mem[q_idx[rd_ptr]];
        o_id_response <= q_id[rd_ptr];
      end
    end
  end

  // Queue payload and backing store are not reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      q_write[wr_ptr] <= i_write;
      q_idx[wr_ptr]   <= req_idx_c;
      q_slot[wr_ptr]  <= req_slot_c;
      q_data[wr_ptr]  <= i_data;
      q_id[wr_ptr]    <= o_id_request;
    end
    if (mem_we_c)
      mem[q_idx[rd_ptr]][int'(q_slot[rd_ptr]) * REG_WIDTH +: REG_WIDTH] <= q_data[rd_ptr];
  end

`ifdef MEM_RESP_STATS_EN
  logic read_done_c;
  assign read_done_c = (state_q == RESP) & i_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_read_count  <= '0;
      o_write_count <= '0;
    end else begin
      if (read_done_c && (o_read_count != 16'hFFFF)) o_read_count <= o_read_count + 16'd1;
      if (mem_we_c && (o_write_count != 16'hFFFF)) o_write_count <= o_write_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed scenarios plus randomized traffic
// against a transaction-level model. Define MEM_RESP_STATS_EN to cover the counters.
module tb_mem_resp;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, wr = 1'b0, ack = 1'b0;
  logic [31:0]  addr = '0, data = '0;
  logic         o_full, o_enable;
  logic [127:0] o_data;
  logic [3:0]   o_id_request, o_id_response;
`ifdef MEM_RESP_STATS_EN
  logic [15:0]  read_count, write_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_resp dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (en),
    .i_addr        (addr),
    .i_data        (data),
    .i_write       (wr),
    .i_ack         (ack),
    .o_full        (o_full),
    .o_enable      (o_enable),
    .o_data        (o_data),
    .o_id_request  (o_id_request),
    .o_id_response (o_id_response)
`ifdef MEM_RESP_STATS_EN
    ,
    .o_read_count  (read_count),
    .o_write_count (write_count)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; wr = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_resp(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      if (o_enable) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #2;
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
    checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", o_enable); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", o_data); end
    checks++; if (o_id_request !== 4'd0) begin errors++; $display("FAIL reset_id_req got %0d exp 0", o_id_request); end
    checks++; if (o_id_response !== 4'd0) begin errors++; $display("FAIL reset_id_resp got %0d exp 0", o_id_response); end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    en = 1'b1; wr = 1'b0; addr = 32'h0; ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (o_enable !== (k == LAT + 1)) begin
        errors++; $display("FAIL latency_edge%0d got %b exp %b", k, o_enable, (k == LAT + 1));
      end
      if (k == LAT + 1) begin
        checks++;
        if (o_id_response !== 4'd0) begin errors++; $display("FAIL latency_id got %0d exp 0", o_id_response); end
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_write_read();
    bit seen;
    do_reset();
    en = 1'b1; wr = 1'b1; addr = 32'h104; data = 32'hDEADBEEF;
    @(negedge clk);
    wr = 1'b0; addr = 32'h100;
    @(negedge clk);
    en = 1'b0;
    wait_resp(seen);
    checks++; if (!seen) begin errors++; $display("FAIL wr_rd_timeout got 0 exp 1"); end
    checks++; if (o_data[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data got %h exp deadbeef", o_data[63:32]); end
    checks++; if (o_id_response !== 4'd0) begin errors++; $display("FAIL wr_rd_id got %0d exp 0", o_id_response); end
    repeat (3) @(negedge clk);
    checks++;
    if (o_enable !== 1'b1 || o_data[63:32] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_rd_hold got en=%b data=%h exp en=1 data=deadbeef", o_enable, o_data[63:32]);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL wr_rd_ack got %b exp 0", o_enable); end
  endtask

  task automatic test_full();
    bit seen;
    do_reset();
    ack = 1'b0; en = 1'b1; wr = 1'b0; addr = 32'h0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_full !== (i >= DEPTH)) begin errors++; $display("FAIL full_flag%0d got %b exp %b", i, o_full, (i >= DEPTH)); end
      checks++;
      if (o_id_request !== 4'((i < DEPTH) ? i : DEPTH)) begin
        errors++; $display("FAIL full_id_req%0d got %0d exp %0d", i, o_id_request, (i < DEPTH) ? i : DEPTH);
      end
    end
    en = 1'b0;
    wait_resp(seen);
    checks++;
    if (!seen || o_id_response !== 4'd0) begin
      errors++; $display("FAIL full_first_resp got seen=%b id=%0d exp seen=1 id=0", seen, o_id_response);
    end
  endtask

  task automatic test_id_wrap();
    bit seen;
    do_reset();
    ack = 1'b1;
    for (int n = 0; n < 17; n++) begin
      @(negedge clk);
      en = 1'b1; wr = 1'b0; addr = 32'h0;
      @(negedge clk);
      en = 1'b0;
      wait_resp(seen);
      checks++;
      if (!seen || o_id_response !== 4'(n % 16)) begin
        errors++; $display("FAIL id_wrap%0d got seen=%b id=%0d exp id=%0d", n, seen, o_id_response, n % 16);
      end
    end
    @(negedge clk);
    checks++; if (o_id_request !== 4'd1) begin errors++; $display("FAIL id_wrap_next got %0d exp 1", o_id_request); end
    ack = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    bit seen;
    bit any;
    do_reset();
    ack = 1'b0; en = 1'b1; wr = 1'b0; addr = 32'h40;
    repeat (3) @(negedge clk);
    en = 1'b0;
    wait_resp(seen);
    checks++; if (!seen) begin errors++; $display("FAIL rst_resp_reach got 0 exp 1"); end
    rst = 1'b0;
    #1;
    checks++; if (o_enable !== 1'b0) begin errors++; $display("FAIL rst_resp_enable got %b exp 0", o_enable); end
    checks++; if (o_id_response !== 4'd0) begin errors++; $display("FAIL rst_resp_id got %0d exp 0", o_id_response); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (o_id_request !== 4'd0) begin errors++; $display("FAIL rst_resp_id_req got %0d exp 0", o_id_request); end
    ack = 1'b1;
    any = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any |= o_enable;
    end
    checks++; if (any !== 1'b0) begin errors++; $display("FAIL rst_resp_ghost got %b exp 0", any); end
    ack = 1'b0;
  endtask

  // Transaction-level model: FIFO of requests; the head's service ends LAT edges
  // after the edge on which it starts, and a read then waits for an ack.
  typedef struct {
    bit          w;
    int          line;
    int          slot;
    logic [31:0] d;
    logic [3:0]  id;
  } req_t;

  logic [127:0] mmem [8];

  task automatic test_random();
    req_t         mq[$];
    req_t         r;
    bit           mbusy, mresp, full, acc;
    int           mend, e, k, line, off, sz;
    logic [127:0] mrdata;
    logic [3:0]   mrid, mid;
    do_reset();
    mbusy = 0; mresp = 0; mend = 0; e = 0; k = 0; mid = '0;
    mrdata = '0; mrid = '0;
    for (int it = 0; it < 1000; it++) begin
      checks++;
      if (o_full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_full@%0d got %b exp %b", it, o_full, (mq.size() == DEPTH)); end
      checks++;
      if (o_enable !== mresp) begin errors++; $display("FAIL rnd_enable@%0d got %b exp %b", it, o_enable, mresp); end
      checks++;
      if (o_id_request !== mid) begin errors++; $display("FAIL rnd_id_req@%0d got %0d exp %0d", it, o_id_request, mid); end
      if (mresp) begin
        checks++;
        if (o_data !== mrdata) begin errors++; $display("FAIL rnd_data@%0d got %h exp %h", it, o_data, mrdata); end
        checks++;
        if (o_id_response !== mrid) begin errors++; $display("FAIL rnd_id_resp@%0d got %0d exp %0d", it, o_id_response, mrid); end
      end
      if (k < 32) begin
        en = 1'b1; wr = 1'b1; line = k / 4; off = (k % 4) * 4;
      end else begin
        en = ($urandom_range(0, 99) < 60);
        wr = 1'($urandom_range(0, 1));
        line = int'($urandom_range(0, 7));
        off = int'($urandom_range(0, 15));
      end
      addr = ($urandom & 32'hFFFF_F000) | 32'(line << 4) | 32'(off);
      data = $urandom;
      ack  = ($urandom_range(0, 99) < 50);
      @(posedge clk);
      sz   = mq.size();
      full = (sz == DEPTH);
      acc  = en && !full;
      if (mresp) begin
        if (ack) begin
          void'(mq.pop_front());
          mresp = 0; mbusy = 0;
        end
      end else if (mbusy) begin
        if (e == mend) begin
          if (mq[0].w) begin
            mmem[mq[0].line][mq[0].slot * 32 +: 32] = mq[0].d;
            void'(mq.pop_front());
            mbusy = 0;
          end else begin
            mresp = 1; mrdata = mmem[mq[0].line]; mrid = mq[0].id;
          end
        end
      end else if (sz > 0) begin
        mbusy = 1; mend = e + LAT;
      end
      if (acc) begin
        r.w = wr; r.line = line; r.slot = off / 4; r.d = data; r.id = wr ? 4'd0 : mid;
        mq.push_back(r);
        if (!wr) mid = mid + 4'd1;
        if (k < 32) k++;
      end
      e++;
      @(negedge clk);
    end
    en = 1'b0; ack = 1'b0;
  endtask

`ifdef MEM_RESP_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++; if (read_count !== 16'd0) begin errors++; $display("FAIL stats_rd_reset got %0d exp 0", read_count); end
    checks++; if (write_count !== 16'd0) begin errors++; $display("FAIL stats_wr_reset got %0d exp 0", write_count); end
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; wr = (i % 2 == 1); addr = 32'h200; data = $urandom;
      @(negedge clk);
      en = 1'b0;
      repeat (10) @(negedge clk);
    end
    checks++; if (read_count !== 16'd3) begin errors++; $display("FAIL stats_rd got %0d exp 3", read_count); end
    checks++; if (write_count !== 16'd2) begin errors++; $display("FAIL stats_wr got %0d exp 2", write_count); end
    ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_write_read();
    test_full();
    test_id_wrap();
    test_reset_in_resp();
    test_random();
`ifdef MEM_RESP_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
